sum_datapath: RTL and testbench
===============================

// Module: sum_datapath
// PURPOSE
//  Datapath for the dedicated Sum CPU; consumes the Sum controller's select/load strobes and returns the loop flag oAlt.
//  Holds register A (loop index), register Sum (accumulator) and an output buffer, all fed by one shared adder.
//  Default build computes 0+1+...+LIMIT (55 for LIMIT=10) and presents it on oOutData with a valid flag.
// PARAMETERS
//  DATA_W    8    width of A, Sum, adder and oOutData
//  LIMIT     10   loop bound; oAlt = (A <= LIMIT), unsigned compare
// PORTS
//  iClk        in   1       clock, all state on rising edge
//  iRst        in   1       synchronous, active-high reset
//  iASrcSel    in   1       A next-value select: 0 = constant 0, 1 = adder result
//  iALoad      in   1       A load enable
//  iSumSrcSel  in   1       Sum next-value select: 0 = constant 0, 1 = adder result
//  iSumLoad    in   1       Sum load enable
//  iOutBufSel  in   1       output buffer load enable (captures Sum)
//  iAddSrcSel  in   1       adder operands: 0 = A + 1, 1 = Sum + A
//  oAlt        out  1       loop-continue flag, (A <= LIMIT), combinational from A register
//  oOutData    out  DATA_W  output buffer contents
//  oOutValid   out  1       sticky: set the cycle after first buffer load
//  oOvf        out  1       sticky adder carry-out flag (SUM_DP_OVF_EN only)
// BEHAVIOUR
//  - Reset (iRst=1 at edge): A=0, Sum=0, OutBuf=0, oOutValid=0, oOvf=0; overrides every strobe. oAlt=1 after reset.
//  - Reset mid-computation: same values next cycle; no partial result survives in OutBuf.
//  - Adder: single DATA_W-bit unsigned adder, result = selected operands mod 2^DATA_W; carry-out feeds oOvf only.
//  - A: if iALoad, A <= iASrcSel ? adder : 0; else hold. Sum: if iSumLoad, Sum <= iSumSrcSel ? adder : 0; else hold.
//  - Both loads in one cycle with SrcSel=1: both registers take the same adder result (one adder, one value).
//  - Loads with SrcSel=0 ignore iAddSrcSel entirely.
//  - OutBuf: if iOutBufSel, OutBuf <= current Sum (pre-update value), oOutValid <= 1; else hold. Latency 1 cycle.
//  - iOutBufSel together with iSumLoad: OutBuf gets old Sum; Sum updates normally.
//  - oOutValid cleared only by reset; repeated buffer loads overwrite oOutData.
//  - oAlt: zero-latency from A; A wrap-around (A=2^DATA_W-1, +1) gives A=0 and oAlt=1 -- no saturation.
//  - Expected strobe sequence per iteration: SumLoad+SumSrcSel+AddSrcSel=1, then ALoad+ASrcSel+AddSrcSel=0.
//  - No internal FSM; the block is strictly strobe-driven and never self-initiates a state change.
// CONFIGURATION
//  SUM_DP_OVF_EN defined: oOvf exists; set to 1 on any edge where a register loads from the adder and the carry-out is 1.
//    Cleared only by reset, and it never alters data (results still wrap).
//  SUM_DP_OVF_EN undefined: port oOvf absent, no carry logic; data behaviour identical.
// STRUCTURE
//  sum_pkg: DATA_W/LIMIT defaults, localparams A_SRC_ZERO/A_SRC_ADD, SUM_SRC_ZERO/SUM_SRC_ADD,
//    ADD_SRC_INC (0)/ADD_SRC_ACC (1); also shared by the Sum controller.
//  Sub-module sum_ld_reg (DATA_W, sync reset, load enable, 2:1 source mux) instantiated for A and Sum;
//    OutBuf uses it with the mux tied.
//  Adder, operand mux, comparator and overflow flag live in the top module.
// TESTING
//  1. Reset, then drive the controller strobe sequence to completion -> oAlt falls when A=11; oOutData=55, oOutValid=1.
//  2. Comparator edge: load A=10 -> oAlt=1 same cycle; one increment (A=11) -> oAlt=0.
//  3. Assert iRst during iteration with A=6, Sum=15 -> next cycle A=0, Sum=0, OutBuf=0, oOutValid=0, oAlt=1.
//  4. DATA_W=5, LIMIT=10, SUM_DP_OVF_EN -> oOutData=23 (55 mod 32), oOvf=1; without the macro oOutData=23, no oOvf.
//  5. iOutBufSel with iSumLoad (Sum=10, A=4, AddSrcSel=1) -> oOutData=10, Sum=14.
//  6. Idle, all strobes 0 for 20 cycles after a result -> A, Sum, oOutData, oOutValid unchanged.

Source files
------------

// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
// Shared constants for the Sum CPU datapath (sum_datapath) and its controller.
//  - DATA_W_DEF / LIMIT_DEF : default datapath width and loop bound
//  - A_SRC_* / SUM_SRC_*    : encodings of iASrcSel / iSumSrcSel
//  - ADD_SRC_*              : encodings of iAddSrcSel (adder operand select)
// -----------------------------------------------------------------------------
package sum_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LIMIT_DEF  = 10;

    // Register next-value source selects
    localparam logic A_SRC_ZERO   = 1'b0;
    localparam logic A_SRC_ADD    = 1'b1;
    localparam logic SUM_SRC_ZERO = 1'b0;
    localparam logic SUM_SRC_ADD  = 1'b1;

    // Adder operand selects: INC = A + 1, ACC = Sum + A
    localparam logic ADD_SRC_INC  = 1'b0;
    localparam logic ADD_SRC_ACC  = 1'b1;

endpackage : sum_pkg

// File: rtl/sum_ld_reg.sv
// -----------------------------------------------------------------------------
// sum_ld_reg
// DATA_W-bit register with synchronous active-high reset, load enable and a
// 2:1 source mux in front of it.
// Ports:
//  iClk    in   1       clock
//  iRst    in   1       synchronous active-high reset (clears to 0)
//  iLoad   in   1       load enable; register holds when low
//  iSrcSel in   1       source select: 0 = iSrc0, 1 = iSrc1
//  iSrc0   in   DATA_W  source 0
//  iSrc1   in   DATA_W  source 1
//  oQ      out  DATA_W  register contents
// -----------------------------------------------------------------------------
module sum_ld_reg #(
    parameter int DATA_W = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iLoad,
    input  logic              iSrcSel,
    input  logic [DATA_W-1:0] iSrc0,
    input  logic [DATA_W-1:0] iSrc1,
    output logic [DATA_W-1:0] oQ
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_src;

    assign w_src = iSrcSel ? iSrc1 : iSrc0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_q <= '0;
        end else if (iLoad) begin
            r_q <= w_src;
        end
    end

    assign oQ = r_q;

endmodule : sum_ld_reg

// File: rtl/sum_datapath.sv
// -----------------------------------------------------------------------------
// sum_datapath
// Strobe-driven datapath of the Sum CPU. Holds the loop index A, the
// accumulator Sum and an output buffer, all fed by one shared adder.
// With the controller's strobe sequence it computes 0+1+...+LIMIT.
//
// Optional build macro: SUM_DP_OVF_EN adds the sticky overflow flag oOvf.
//
// Ports:
//  iClk        in   1       clock
//  iRst        in   1       synchronous active-high reset
//  iASrcSel    in   1       A source: 0 = zero, 1 = adder
//  iALoad      in   1       A load enable
//  iSumSrcSel  in   1       Sum source: 0 = zero, 1 = adder
//  iSumLoad    in   1       Sum load enable
//  iOutBufSel  in   1       output buffer load (captures current Sum)
//  iAddSrcSel  in   1       adder operands: 0 = A + 1, 1 = Sum + A
//  oAlt        out  1       (A <= LIMIT), combinational from A
//  oOutData    out  DATA_W  output buffer contents
//  oOutValid   out  1       sticky, set after the first buffer load
//  oOvf        out  1       sticky adder carry flag (SUM_DP_OVF_EN only)
// -----------------------------------------------------------------------------
module sum_datapath
    import sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,  // must be <= 32 for the compare below
    parameter int LIMIT  = LIMIT_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iASrcSel,
    input  logic              iALoad,
    input  logic              iSumSrcSel,
    input  logic              iSumLoad,
    input  logic              iOutBufSel,
    input  logic              iAddSrcSel,
    output logic              oAlt,
    output logic [DATA_W-1:0] oOutData,
    output logic              oOutValid
`ifdef SUM_DP_OVF_EN
    ,
    output logic              oOvf
`endif
);

    localparam logic [31:0] LIMIT_U = 32'(LIMIT);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_op_x;
    logic [DATA_W-1:0] w_op_y;
    logic [DATA_W-1:0] w_add;
    logic              r_out_valid;

    // Shared operand mux: INC -> A + 1, ACC -> Sum + A
    assign w_op_x = (iAddSrcSel == ADD_SRC_ACC) ? w_sum : w_a;
    assign w_op_y = (iAddSrcSel == ADD_SRC_ACC) ? w_a   : DATA_W'(1);

`ifdef SUM_DP_OVF_EN
    logic [DATA_W:0] w_add_full;
    logic            w_adder_used;
    logic            r_ovf;

    assign w_add_full   = {1'b0, w_op_x} + {1'b0, w_op_y};
    assign w_add        = w_add_full[DATA_W-1:0];
    // Carry only matters when some register actually takes the adder result
    assign w_adder_used = (iALoad   && (iASrcSel   == A_SRC_ADD)) ||
                          (iSumLoad && (iSumSrcSel == SUM_SRC_ADD));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ovf <= 1'b0;
        end else if (w_adder_used && w_add_full[DATA_W]) begin
            r_ovf <= 1'b1;
        end
    end

    assign oOvf = r_ovf;
`else
    assign w_add = w_op_x + w_op_y;
`endif

    sum_ld_reg #(.DATA_W(DATA_W)) u_a_reg (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (iALoad),
        .iSrcSel (iASrcSel),
        .iSrc0   ('0),
        .iSrc1   (w_add),
        .oQ      (w_a)
    );

    sum_ld_reg #(.DATA_W(DATA_W)) u_sum_reg (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (iSumLoad),
        .iSrcSel (iSumSrcSel),
        .iSrc0   ('0),
        .iSrc1   (w_add),
        .oQ      (w_sum)
    );

    // Output buffer always captures the pre-update Sum; mux tied to source 1
    sum_ld_reg #(.DATA_W(DATA_W)) u_outbuf_reg (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (iOutBufSel),
        .iSrcSel (1'b1),
        .iSrc0   ('0),
        .iSrc1   (w_sum),
        .oQ      (oOutData)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_out_valid <= 1'b0;
        end else if (iOutBufSel) begin
            r_out_valid <= 1'b1;
        end
    end

    assign oOutValid = r_out_valid;

    // Unsigned compare; A wraps freely so oAlt returns to 1 after wrap-around
    assign oAlt = (32'(w_a) <= LIMIT_U);

endmodule : sum_datapath

// File: tb/tb_sum_datapath.sv
// -----------------------------------------------------------------------------
// tb_sum_datapath
// Self-checking bench for sum_datapath (DATA_W=8, LIMIT=10). A behavioural
// model kept as plain integers tracks A, Sum, the output buffer and the
// sticky flags; every cycle the visible outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_sum_datapath;

    localparam int W     = 8;
    localparam int LIM   = 10;
    localparam int MODV  = 1 << W;

    logic         iClk;
    logic         iRst;
    logic         iASrcSel;
    logic         iALoad;
    logic         iSumSrcSel;
    logic         iSumLoad;
    logic         iOutBufSel;
    logic         iAddSrcSel;
    logic         oAlt;
    logic [W-1:0] oOutData;
    logic         oOutValid;
`ifdef SUM_DP_OVF_EN
    logic         oOvf;
`endif

    sum_datapath #(.DATA_W(W), .LIMIT(LIM)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iASrcSel   (iASrcSel),
        .iALoad     (iALoad),
        .iSumSrcSel (iSumSrcSel),
        .iSumLoad   (iSumLoad),
        .iOutBufSel (iOutBufSel),
        .iAddSrcSel (iAddSrcSel),
        .oAlt       (oAlt),
        .oOutData   (oOutData),
        .oOutValid  (oOutValid)
`ifdef SUM_DP_OVF_EN
        ,
        .oOvf       (oOvf)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference model state
    int unsigned m_a, m_sum, m_out;
    bit          m_valid, m_ovf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alt"},   32'(oAlt),      32'(m_a <= LIM));
        chk({tag, ".data"},  32'(oOutData),  m_out);
        chk({tag, ".valid"}, 32'(oOutValid), 32'(m_valid));
`ifdef SUM_DP_OVF_EN
        chk({tag, ".ovf"},   32'(oOvf),      32'(m_ovf));
`endif
    endtask

    // Apply one cycle of strobes, advance the model, then check outputs.
    task automatic step(input bit rst, input bit a_sel, input bit a_ld,
                        input bit s_sel, input bit s_ld, input bit ob,
                        input bit add_sel, input string tag);
        int unsigned full, res;
        int unsigned n_a, n_sum, n_out;
        bit          n_valid, n_ovf;
        iRst = rst; iASrcSel = a_sel; iALoad = a_ld;
        iSumSrcSel = s_sel; iSumLoad = s_ld; iOutBufSel = ob; iAddSrcSel = add_sel;
        full = add_sel ? (m_sum + m_a) : (m_a + 1);
        res  = full % MODV;
        if (rst) begin
            n_a = 0; n_sum = 0; n_out = 0; n_valid = 0; n_ovf = 0;
        end else begin
            n_a     = a_ld ? (a_sel ? res : 0) : m_a;
            n_sum   = s_ld ? (s_sel ? res : 0) : m_sum;
            n_out   = ob ? m_sum : m_out;
            n_valid = m_valid | ob;
            n_ovf   = m_ovf | ((full >= MODV) && ((a_ld && a_sel) || (s_ld && s_sel)));
        end
        @(posedge iClk);
        #1;
        m_a = n_a; m_sum = n_sum; m_out = n_out; m_valid = n_valid; m_ovf = n_ovf;
        $display("step %-10s rst=%0b A=%0d Sum=%0d alt=%0b out=%0d valid=%0b",
                 tag, rst, m_a, m_sum, oAlt, oOutData, oOutValid);
        check_all(tag);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, "reset");
    endtask
    task automatic init_regs();  // A=0, Sum=0 via zero sources, adder select random
        step(0, 0, 1, 0, 1, 0, 1'($urandom), "init");
    endtask
    task automatic sum_step();
        step(0, 0, 0, 1, 1, 0, 1, "sumstep");
    endtask
    task automatic inc_step();
        step(0, 1, 1, 0, 0, 0, 0, "incstep");
    endtask

    initial begin
        int guard;
        iRst = 1'b1; iASrcSel = 0; iALoad = 0; iSumSrcSel = 0;
        iSumLoad = 0; iOutBufSel = 0; iAddSrcSel = 0;
        m_a = 0; m_sum = 0; m_out = 0; m_valid = 0; m_ovf = 0;

        // 1. Reset state and full summation run
        do_reset();
        do_reset();
        chk("reset.alt_const", 32'(oAlt), 32'd1);
        init_regs();
        guard = 0;
        while (m_a <= LIM && guard < 40) begin
            sum_step();
            inc_step();
            guard++;
        end
        chk("run.bounded", 32'(guard < 40), 32'd1);
        chk("run.alt_low", 32'(oAlt), 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, "capture");
        chk("run.result55", 32'(oOutData), 32'd55);
        chk("run.valid", 32'(oOutValid), 32'd1);

        // 6. Idle for 20 cycles: everything holds
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom), 0, 1'($urandom), 0, 0, 1'($urandom), "idle");
        chk("idle.result55", 32'(oOutData), 32'd55);

        // 2. Comparator edge: A=10 -> alt=1, A=11 -> alt=0
        do_reset();
        for (int i = 0; i < 10; i++) inc_step();
        chk("edge.a10_alt", 32'(oAlt), 32'd1);
        inc_step();
        chk("edge.a11_alt", 32'(oAlt), 32'd0);

        // 3. Reset mid-computation at A=6, Sum=15 with a stale buffer
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0, "buf0");
        for (int i = 0; i < 6; i++) begin
            sum_step();
            inc_step();
        end
        step(0, 0, 0, 0, 0, 1, 0, "buf15");
        chk("mid.buf15", 32'(oOutData), 32'd15);
        do_reset();
        chk("mid.data0", 32'(oOutData), 32'd0);
        chk("mid.valid0", 32'(oOutValid), 32'd0);
        chk("mid.alt1", 32'(oAlt), 32'd1);

        // 5. Buffer capture together with Sum update (Sum=10, A=4)
        for (int i = 0; i < 4; i++) begin
            sum_step();
            inc_step();
        end
        sum_step();
        step(0, 0, 0, 1, 1, 1, 1, "bufsum");
        chk("bufsum.old10", 32'(oOutData), 32'd10);
        step(0, 0, 0, 0, 0, 1, 0, "bufnew");
        chk("bufsum.new14", 32'(oOutData), 32'd14);

        // A wrap-around: 255 -> 0 gives alt=1 again
        do_reset();
        for (int i = 0; i < MODV - 1; i++)
            step(0, 1, 1, 0, 0, 0, 0, "wrapinc");
        chk("wrap.a255_alt", 32'(oAlt), 32'd0);
        inc_step();
        chk("wrap.a0_alt", 32'(oAlt), 32'd1);

        // Randomized strobes against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sum_datapath
